gpr_writeback: RTL and testbench

Writeback stage that owns the write port of the general-purpose register file. Merges single-cycle ALU results with out-of-order load returns, buffers load returns in a small FIFO when the write port is busy, and keeps a pending-load scoreboard for the hazard unit. Sits between the EX/MEM pipeline and the GPR file's `write_enable`/`waddr`/`wdata` inputs.

---
 rtl/gpr_writeback_pkg.sv | 36 +++
 rtl/gpr_writeback_if.sv | 35 +++
 rtl/gpr_wb_fifo.sv | 65 ++++++
 rtl/gpr_writeback.sv | 103 ++++++++++
 tb/tb_gpr_writeback.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_writeback_pkg.sv
// Shared register-file geometry and writeback-stage types.
package gpr_writeback_pkg;

  localparam logic ENABLE        = 1'b1;
  localparam logic DISABLE       = 1'b0;
  localparam int   REGS_NUM_LOG  = 5;
  localparam int   REGS_NUM      = 1 << REGS_NUM_LOG;
  localparam int   ADDR_W        = REGS_NUM_LOG;
  localparam int   DATA_W        = 32;
  localparam int   WB_FIFO_DEPTH = 2;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [REGS_NUM-1:0] reg_mask_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_t;

  // One-hot register mask; r0 is hardwired and never tracked.
  function automatic reg_mask_t reg_mask(input reg_addr_t a);
    reg_mask_t m;
    m = '0;
    if (a != '0) m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gpr_writeback_if.sv
// Pipeline-side bundle of the writeback stage: ALU results, load issue/return, GPR write port, scoreboard.
interface gpr_writeback_if;
  import gpr_writeback_pkg::*;

  logic      alu_valid;
  reg_addr_t alu_waddr;
  reg_data_t alu_wdata;
  logic      load_issue;
  reg_addr_t load_issue_addr;
  logic      load_valid;
  logic      load_ready;
  reg_addr_t load_waddr;
  reg_data_t load_wdata;
  logic      write_enable;
  reg_addr_t waddr;
  reg_data_t wdata;
  reg_mask_t pending;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output load_issue, load_issue_addr,
    output load_valid, load_waddr, load_wdata,
    input  load_ready,
    input  write_enable, waddr, wdata, pending
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  load_issue, load_issue_addr,
    input  load_valid, load_waddr, load_wdata,
    output load_ready,
    output write_enable, waddr, wdata, pending
  );

endinterface

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO of {addr, data} load returns; head is visible combinationally.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module gpr_wb_fifo
  import gpr_writeback_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  wb_entry_t push_dat_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries behind a valid count are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/gpr_writeback.sv
// Owns the GPR write port: ALU first, then buffered loads, then bypassed loads; one registered write per cycle.
// Tracks outstanding loads per register for the hazard unit.
module gpr_writeback
  import gpr_writeback_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  gpr_writeback_if.slave wb_if
);

  wb_entry_t fifo_head;
  wb_entry_t load_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;
  logic      load_xfer;

  wb_src_t   sel_src;
  wb_entry_t sel_entry;

  logic      we_q,      we_d;
  reg_addr_t waddr_q,   waddr_d;
  reg_data_t wdata_q,   wdata_d;
  reg_mask_t pending_q, pending_d;
  reg_mask_t clr_mask;
  reg_mask_t set_mask;

  assign load_entry       = '{addr: wb_if.load_waddr, data: wb_if.load_wdata};
  assign wb_if.load_ready = !fifo_full && !rst_i;
  assign load_xfer        = wb_if.load_valid && wb_if.load_ready;

  gpr_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_dat_i (load_entry),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // A returning load bypasses only when nothing older is queued, keeping return order.
  always_comb begin
    sel_src   = SRC_NONE;
    sel_entry = '0;
    fifo_pop  = DISABLE;
    fifo_push = DISABLE;
    if (wb_if.alu_valid) begin
      sel_src   = SRC_ALU;
      sel_entry = '{addr: wb_if.alu_waddr, data: wb_if.alu_wdata};
      fifo_push = load_xfer;
    end else if (!fifo_empty) begin
      sel_src   = SRC_FIFO;
      sel_entry = fifo_head;
      fifo_pop  = ENABLE;
      fifo_push = load_xfer;
    end else if (load_xfer) begin
      sel_src   = SRC_BYPASS;
      sel_entry = load_entry;
    end
  end

  always_comb begin
    we_d    = (sel_src != SRC_NONE) && (sel_entry.addr != '0);
    waddr_d = we_d ? sel_entry.addr : waddr_q;
    wdata_d = we_d ? sel_entry.data : wdata_q;
  end

  // Set beats clear so a re-issue racing the previous writeback stays pending.
  always_comb begin
    clr_mask  = '0;
    set_mask  = '0;
    if (sel_src == SRC_FIFO || sel_src == SRC_BYPASS) clr_mask = reg_mask(sel_entry.addr);
    if (wb_if.load_issue) set_mask = reg_mask(wb_if.load_issue_addr);
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign wb_if.write_enable = we_q;
  assign wb_if.waddr        = waddr_q;
  assign wb_if.wdata        = wdata_q;
  assign wb_if.pending      = pending_q;

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: expected GPR writes queued at stimulus time, checked by a write-port monitor.
module tb_gpr_writeback;
  import gpr_writeback_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_entry_t exp_q[$];

  gpr_writeback_if bus();

  gpr_writeback #(
    .DEPTH (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid       = 1'b0;
    bus.alu_waddr       = '0;
    bus.alu_wdata       = '0;
    bus.load_issue      = 1'b0;
    bus.load_issue_addr = '0;
    bus.load_valid      = 1'b0;
    bus.load_waddr      = '0;
    bus.load_wdata      = '0;
  endtask

  task automatic drive_alu(input int a, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_waddr = reg_addr_t'(a);
    bus.alu_wdata = d;
  endtask

  task automatic drive_load(input int a, input logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_waddr = reg_addr_t'(a);
    bus.load_wdata = d;
  endtask

  task automatic issue(input int a);
    bus.load_issue      = 1'b1;
    bus.load_issue_addr = reg_addr_t'(a);
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    exp_q.push_back('{addr: reg_addr_t'(a), data: d});
  endtask

  // Write-port monitor: every registered write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got r%0d=%h required no write", bus.waddr, bus.wdata);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.waddr), 64'(e.addr));
        check("wr_data", 64'(bus.wdata), 64'(e.data));
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_we",      64'(bus.write_enable), 64'd0);
    check("rst_waddr",   64'(bus.waddr),        64'd0);
    check("rst_wdata",   64'(bus.wdata),        64'd0);
    check("rst_pending", 64'(bus.pending),      64'd0);
    check("rst_ready",   64'(bus.load_ready),   64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(bus.load_ready), 64'd1);

    // ALU path, including an r0 write that must be suppressed
    drive_alu(5, 32'h1234);
    expect_wr(5, 32'h1234);
    tick();
    check("alu_we", 64'(bus.write_enable), 64'd1);
    drive_alu(0, 32'h55);
    tick();
    check("alu_r0_we",    64'(bus.write_enable), 64'd0);
    check("alu_r0_waddr", 64'(bus.waddr),        64'd5);
    check("alu_r0_wdata", 64'(bus.wdata),        64'h1234);
    idle();
    tick();

    // Bypass: empty FIFO, no ALU
    issue(7);
    tick();
    check("pend7_set", 64'(bus.pending), 64'h80);
    idle();
    drive_load(7, 32'hAAAA);
    expect_wr(7, 32'hAAAA);
    tick();
    check("bypass_we",    64'(bus.write_enable), 64'd1);
    check("pend7_clear",  64'(bus.pending),      64'd0);
    idle();
    tick();

    // Conflict: ALU busy 4 cycles, two loads queue up and drain in order
    for (int i = 0; i < 4; i++) expect_wr(10 + i, 32'h100 + i);
    expect_wr(3, 32'h3);
    expect_wr(4, 32'h4);
    for (int i = 0; i < 4; i++) begin
      idle();
      drive_alu(10 + i, 32'h100 + i);
      if (i == 0) drive_load(3, 32'h3);
      if (i == 1) drive_load(4, 32'h4);
      tick();
      if (i == 1) check("full_ready", 64'(bus.load_ready), 64'd0);
      if (i == 3) check("full_ready_held", 64'(bus.load_ready), 64'd0);
    end
    idle();
    tick();
    check("drain_ready", 64'(bus.load_ready), 64'd1);
    tick();
    tick();
    check("drain_idle_we", 64'(bus.write_enable), 64'd0);

    // Scoreboard race: set wins over clear; r0 never tracked
    issue(9);
    tick();
    check("pend9_set", 64'(bus.pending), 64'h200);
    issue(9);
    drive_load(9, 32'h99);
    expect_wr(9, 32'h99);
    tick();
    check("race_set_wins", 64'(bus.pending), 64'h200);
    idle();
    issue(0);
    tick();
    check("r0_issue", 64'(bus.pending), 64'h200);
    idle();
    drive_load(9, 32'h999);
    expect_wr(9, 32'h999);
    tick();
    check("pend9_clear", 64'(bus.pending), 64'd0);
    idle();
    tick();

    // Simultaneous push/pop with one entry buffered
    drive_alu(20, 32'h2000);
    drive_load(21, 32'h21);
    expect_wr(20, 32'h2000);
    expect_wr(21, 32'h21);
    expect_wr(22, 32'h22);
    tick();
    idle();
    drive_load(22, 32'h22);
    tick();
    check("pushpop_ready", 64'(bus.load_ready), 64'd1);
    idle();
    tick();
    check("pushpop_last_we", 64'(bus.write_enable), 64'd1);
    tick();
    check("pushpop_empty_we", 64'(bus.write_enable), 64'd0);

    // Reset mid-operation with a full FIFO and a pending load
    drive_alu(1, 32'h1);
    drive_load(23, 32'h23);
    issue(25);
    expect_wr(1, 32'h1);
    tick();
    idle();
    drive_alu(2, 32'h2);
    drive_load(24, 32'h24);
    tick();
    idle();
    check("pre_rst_full",    64'(bus.load_ready), 64'd0);
    check("pre_rst_pending", 64'(bus.pending),    64'h0200_0000);
    rst = 1'b1;
    #1;
    check("mid_rst_we",      64'(bus.write_enable), 64'd0);
    check("mid_rst_waddr",   64'(bus.waddr),        64'd0);
    check("mid_rst_pending", 64'(bus.pending),      64'd0);
    check("mid_rst_ready",   64'(bus.load_ready),   64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(bus.load_ready), 64'd1);
    repeat (4) tick();
    check("post_rst_we", 64'(bus.write_enable), 64'd0);

    check("exp_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
